// File: rtl/lector_contadores.sv
// Requester side of the counter read interface: sweeps idx 0..NUM_IDX-1 and latches each count.
// Optional macro LECTOR_SUMA_EN adds a registered 8-bit sum of all captured counts (port suma).
module lector_contadores #(
  parameter int unsigned NUM_IDX = 5,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       valid,
  input  logic [4:0] data,
  output logic       req,
  output logic [2:0] idx,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] cnt0,
  output logic [4:0] cnt1,
  output logic [4:0] cnt2,
  output logic [4:0] cnt3,
`ifdef LECTOR_SUMA_EN
  output logic [4:0] cnt4,
  output logic [7:0] suma
`else
  output logic [4:0] cnt4
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SOLICITAR = 2'd1;
  localparam logic [1:0] ESPERAR   = 2'd2;
  localparam logic [1:0] FIN       = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'(NUM_IDX - 1);
  localparam logic [3:0] TMO      = 4'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] wait_q, wait_d;
  logic       error_q, error_d;
  logic [4:0] cnt_q [5];
  logic [4:0] cnt_d [5];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    error_d = error_q;
    for (int unsigned i = 0; i < 5; i++) cnt_d[i] = cnt_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SOLICITAR;
          idx_d   = '0;
          error_d = 1'b0;
          wait_d  = '0;
        end
      end
      SOLICITAR: begin
        state_d = ESPERAR;
        wait_d  = '0;
      end
      ESPERAR: begin
        if (valid) begin
          // Channels at or above NUM_IDX are never written, so they stay at zero.
          for (int unsigned i = 0; i < 5; i++) begin
            if (i < NUM_IDX && idx_q == 3'(i)) cnt_d[i] = data;
          end
          if (idx_q >= LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SOLICITAR;
          end
        end else begin
          wait_d = (wait_q < TMO) ? wait_q + 4'd1 : TMO;
          if (wait_d == TMO) begin
            error_d = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      error_q <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      error_q <= error_d;
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef LECTOR_SUMA_EN
  logic [7:0] suma_q, suma_d;

  // Sum uses cnt_d so the channel captured on the FIN-entry edge is included.
  always_comb begin
    suma_d = suma_q;
    if (state_q == ESPERAR && state_d == FIN) begin
      suma_d = {3'b000, cnt_d[0]} + {3'b000, cnt_d[1]} + {3'b000, cnt_d[2]}
             + {3'b000, cnt_d[3]} + {3'b000, cnt_d[4]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) suma_q <= '0;
    else       suma_q <= suma_d;
  end

  assign suma = suma_q;
`endif

  assign req   = (state_q == SOLICITAR);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign idx   = idx_q;
  assign error = error_q;
  assign cnt0  = cnt_q[0];
  assign cnt1  = cnt_q[1];
  assign cnt2  = cnt_q[2];
  assign cnt3  = cnt_q[3];
  assign cnt4  = cnt_q[4];

endmodule

// File: tb/tb_lector_contadores.sv
// Scoreboard bench for lector_contadores: randomized responder latencies against a sweep-level model.
module tb_lector_contadores;
  localparam int unsigned N   = 5;
  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       reset, start, valid;
  logic [4:0] data;
  logic       req, busy, done, error;
  logic [2:0] idx;
  logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt4;
`ifdef LECTOR_SUMA_EN
  logic [7:0] suma;
`endif

  lector_contadores #(.NUM_IDX(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .data(data),
    .req(req), .idx(idx), .busy(busy), .done(done), .error(error),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4)
`ifdef LECTOR_SUMA_EN
    , .suma(suma)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] dcnt [5];
  assign dcnt[0] = cnt0;
  assign dcnt[1] = cnt1;
  assign dcnt[2] = cnt2;
  assign dcnt[3] = cnt3;
  assign dcnt[4] = cnt4;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [4:0][4:0] c;
    logic            err;
    logic [31:0]     dcyc;
  } exp_t;

  exp_t sw_q[$];
  int   exp_idx[$];

  // Reference state and responder configuration
  logic [4:0][4:0] m_cnt;
  logic            m_err;
  logic [4:0]      cnts [5];
  int              lat  [5];
  int              cd;
  logic [4:0]      pd;
  bit              stray_req;

  // Responder: valid rises 'lat' cycles after a seen req (lat 0 = never).
  task automatic tick();
    @(negedge clk);
    valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        valid = 1'b1;
        data  = pd;
      end
    end
    if (req) begin
      if (stray_req) begin
        valid = 1'b1;
        data  = 5'd9;
      end
      cd = lat[idx];
      pd = cnts[idx];
    end
  endtask

  task automatic launch(input int hold);
    int   off = 0;
    bit   ab  = 0;
    exp_t e;
    chk("busy_idle", busy, 0);
    chk("err_hold", error, m_err);
    for (int i = 0; i < N; i++) chk("cnt_hold", dcnt[i], m_cnt[i]);
    for (int j = 0; j < N; j++) begin
      if (!ab) begin
        exp_idx.push_back(j);
        if (lat[j] == 0 || lat[j] > TMO) begin
          ab  = 1;
          off += 1 + TMO;
        end else begin
          off += 1 + lat[j];
          m_cnt[j] = cnts[j];
        end
      end
    end
    m_err  = ab;
    e.c    = m_cnt;
    e.err  = ab;
    e.dcyc = cyc + 1 + off;
    sw_q.push_back(e);
    start = 1'b1;
    repeat (hold) tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && sw_q.size() != 0; k++) tick();
    if (sw_q.size() != 0) begin
      chk("sweep_bound", 1, 0);
      sw_q.delete();
      exp_idx.delete();
    end
    repeat (4) tick();
    chk("idx_drained", exp_idx.size(), 0);
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d, input int f);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d; lat[4] = f;
  endtask

  task automatic set_cnts(input int a, input int b, input int c, input int d, input int f);
    cnts[0] = 5'(a); cnts[1] = 5'(b); cnts[2] = 5'(c); cnts[3] = 5'(d); cnts[4] = 5'(f);
  endtask

  // Monitor: pops expectations whenever the DUT presents req or done.
  initial begin
    bit   prev_req;
    bit   prev_done;
    exp_t e;
    int   ei;
    int   s;
    prev_req  = 0;
    prev_done = 0;
    forever begin
      @(posedge clk);
      #2;
      if (req) begin
        chk("req_one_cycle", prev_req, 0);
        chk("err_cleared", error, 0);
        if (exp_idx.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          ei = exp_idx.pop_front();
          chk("req_idx", idx, ei);
        end
      end
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        if (sw_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sw_q.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("done_error", error, e.err);
          chk("done_busy", busy, 1);
          s = 0;
          for (int i = 0; i < N; i++) begin
            chk("done_cnt", dcnt[i], e.c[i]);
            s += e.c[i];
          end
`ifdef LECTOR_SUMA_EN
          chk("done_suma", suma, s);
`endif
        end
      end
      prev_req  = req;
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
    cd = 0; pd = '0; stray_req = 0; m_cnt = '0; m_err = 1'b0;
    set_lat(1, 1, 1, 1, 1);
    set_cnts(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    for (int i = 0; i < N; i++) chk("rst_cnt", dcnt[i], 0);
`ifdef LECTOR_SUMA_EN
    chk("rst_suma", suma, 0);
`endif
    reset = 1'b0;
    tick();

    // Nominal sweep
    set_cnts(3, 0, 7, 15, 1);
    launch(1);
    wait_done();

    // Stray valid in IDLE
    repeat (3) begin
      @(negedge clk);
      valid = 1'b1;
      data  = 5'd9;
    end
    tick();

    // Stray valid in SOLICITAR, channel 2 silent so its old count must survive
    stray_req = 1;
    set_cnts(20, 21, 22, 23, 24);
    set_lat(1, 1, 0, 1, 1);
    launch(1);
    wait_done();
    stray_req = 0;

    // Timeout boundary: lat==TMO captured, lat==TMO+1 aborts
    set_cnts(5, 6, 7, 8, 9);
    set_lat(1, TMO, 1, TMO + 1, 1);
    launch(1);
    wait_done();

    // start held 6 cycles, all-ones counts
    set_cnts(31, 31, 31, 31, 31);
    set_lat(1, 1, 1, 1, 1);
    launch(6);
    wait_done();

    // Reset in ESPERAR on idx 2
    set_cnts(11, 12, 13, 14, 16);
    launch(1);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (busy && !req && !done && idx == 3'd2) seen = 1;
    end
    chk("reach_idx2", seen, 1);
    sw_q.delete();
    exp_idx.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid = 1'b0;
    cd    = 0;
    m_cnt = '0;
    m_err = 1'b0;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < N; i++) chk("mid_rst_cnt", dcnt[i], 0);
    repeat (20) tick();

    // Silent responder
    set_lat(0, 0, 0, 0, 0);
    launch(1);
    wait_done();

    // Randomized sweeps
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        cnts[j] = 5'($urandom_range(0, 31));
        r = $urandom_range(0, 19);
        if (r < 12)       lat[j] = 1;
        else if (r < 17)  lat[j] = $urandom_range(2, TMO);
        else if (r == 17) lat[j] = 0;
        else              lat[j] = TMO + r - 17;
      end
      stray_req = ($urandom_range(0, 3) == 0);
      launch($urandom_range(1, 6));
      wait_done();
      stray_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lector_contadores.md
Name: lector_contadores

Overview:
- Requester side of the counter read interface: issues req/idx to the per-channel push counters and collects the returned data/valid pairs.
- On a start pulse it sweeps idx 0..NUM_IDX-1, latches each returned count into its own output register, then pulses done.
- Sits between the transaction-layer counter bank and the test/report logic, so every channel count can be read with one command.

Parameters:
- NUM_IDX, 5, number of counter channels swept (idx 0..NUM_IDX-1); legal range 1..5.
- TIMEOUT, 8, maximum wait cycles for valid after each req before aborting; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- valid  input  1  responder data-valid; high the cycle after a sampled req.
- data  input  5  responder count value, qualified by valid.
- req  output  1  read request to the responder.
- idx  output  3  channel index accompanying req.
- busy  output  1  high while a sweep is in progress (any state except IDLE).
- done  output  1  one-cycle pulse at the end of a sweep (normal or aborted).
- error  output  1  sticky timeout flag; cleared by reset or by the next accepted start.
- cnt0..cnt4  output  5 each  captured counts for channels 0..4.

Behaviour:
- Reset values (sampled at posedge with reset=1): state IDLE; req=0, idx=0, busy=0, done=0, error=0, cnt0..cnt4=0, wait counter=0.
- Reset takes priority over everything, including mid-sweep. The sweep is abandoned, no done pulse is produced, and captured counts are cleared.
- FSM states: IDLE, SOLICITAR, ESPERAR, FIN. Outputs are decoded from registered state (Moore): req=(state==SOLICITAR), busy=(state!=IDLE), done=(state==FIN). idx is a register.
- IDLE:
  - start=1 -> SOLICITAR, idx=0, error=0, wait counter=0.
  - start=0 -> stay in IDLE.
- SOLICITAR: req=1 for exactly one cycle, then -> ESPERAR with wait counter=0. req is never held for more than one cycle.
- ESPERAR:
  - valid=1 -> cnt[idx]<=data. If idx==NUM_IDX-1 -> FIN; else idx<=idx+1 -> SOLICITAR.
  - valid=0 -> wait counter increments. When it reaches TIMEOUT: error<=1, cnt[idx] left unchanged, -> FIN (remaining channels are not read).
- FIN: done=1 for one cycle -> IDLE. idx holds its last value.
- Nominal latency with a one-cycle responder:
  - start sampled at edge 0; req high during cycle 0->1.
  - Capture for channel i at edge 2i+2.
  - done high during the cycle after edge 2*NUM_IDX (cycle 10->11 for NUM_IDX=5).
- Ignored inputs:
  - start while busy=1.
  - valid while not in ESPERAR (a stray or late valid does not change any cnt).
  - start and reset asserted together: reset wins.
- Width rules:
  - data is stored verbatim; no arithmetic on counts.
  - cnt registers for channels >= NUM_IDX stay 0.
  - idx never exceeds NUM_IDX-1.
  - wait counter is 4 bits and saturates at TIMEOUT.
- Successive sweeps overwrite cnt registers. Values are stable from the capture edge until the next capture or reset.

Optional Feature:
- Macro: LECTOR_SUMA_EN.
- Defined:
  - Adds output port suma (8 bits) = cnt0+...+cnt4, zero-extended; the 8-bit width covers the 5x31=155 maximum with no overflow.
  - Registered: updated on the edge entering FIN, reset to 0, and held until the next FIN.
  - Also updated on aborted sweeps, using whatever channels were captured.
- Not defined: port suma and its adder are absent; all other behaviour is identical.

Test Plan:
- Responder model preloaded with counts 3,0,7,15,1; start pulse at edge 0 -> req pulses on idx 0..4 every 2 cycles; cnt0..cnt4=3,0,7,15,1; done high exactly one cycle after edge 10; error=0; busy low after done.
- Responder never asserts valid -> req on idx 0 only; error=1 and done pulse after 8 wait cycles; all cnt=0. Next start clears error.
- start held high for 6 cycles mid-sweep -> exactly one sweep; idx sequence 0,1,2,3,4 with no restart. A second start after done launches a new sweep overwriting the counts.
- reset asserted while idx=2 in ESPERAR -> next cycle: req=0, busy=0, idx=0, cnt0..cnt4=0, no done pulse.
- Stray valid=1 with data=9 while in IDLE and while in SOLICITAR -> no cnt changes.
- With LECTOR_SUMA_EN and counts 3,0,7,15,1 -> suma=26 from the FIN cycle on. With counts 31,31,31,31,31 -> suma=155.
